// File: rtl/morra_game_ctrl.sv
// Sequencing controller for the morra cinese datapath: setup/evaluate/end strobes,
// round and win bookkeeping against a limit latched at setup, and game-end detection.
module morra_game_ctrl #(
  parameter int BASE_MANCHE = 4,
  parameter int CNT_W       = 5,
  parameter int TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             INIZIO,
  input  logic [1:0]       PRIMO,
  input  logic [1:0]       SECONDO,
  input  logic [1:0]       MANCHE_IN,
  input  logic [1:0]       PARTITA_IN,
  output logic             INIZIO_SETUP,
  output logic             INIZIO_CONTO,
  output logic             FINE_CONTO,
  output logic [1:0]       STATO,
  output logic [CNT_W-1:0] N_MANCHE,
  output logic [1:0]       PARTITA
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_GIOCO = 2'b10,
    S_FINE  = 2'b11
  } state_t;

  state_t           state, next_state;
  logic             vld_p1;
  logic [CNT_W-1:0] n_manche, w1, w2, limit;
  logic [TW-1:0]    to_cnt;
  logic [1:0]       partita;
  logic             setup_q, conto_q, fine_q;

  logic [CNT_W-1:0] n_upd, w1_upd, w2_upd;
  logic [TW-1:0]    to_upd;
  logic [1:0]       res_nxt;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
  endfunction

  function automatic logic [TW-1:0] sat_inc_to(input logic [TW-1:0] x);
    return (x == {TW{1'b1}}) ? x : x + TW'(1);
  endfunction

  function automatic logic [1:0] score_result(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    if (a > b)      return 2'b01;
    else if (b > a) return 2'b10;
    else            return 2'b11;
  endfunction

  // Round accounting: MANCHE_IN is only trusted when vld_p1 is set, i.e. from the
  // second GIOCO cycle on, matching the datapath's one-cycle result latency.
  always_comb begin
    n_upd   = n_manche;
    w1_upd  = w1;
    w2_upd  = w2;
    to_upd  = to_cnt;
    if (state == S_GIOCO && vld_p1) begin
      case (MANCHE_IN)
        2'b01: begin
          n_upd  = sat_inc_cnt(n_manche);
          w1_upd = sat_inc_cnt(w1);
          to_upd = '0;
        end
        2'b10: begin
          n_upd  = sat_inc_cnt(n_manche);
          w2_upd = sat_inc_cnt(w2);
          to_upd = '0;
        end
        2'b11: begin
          n_upd  = sat_inc_cnt(n_manche);
          to_upd = '0;
        end
        default: to_upd = sat_inc_to(to_cnt);
      endcase
    end
  end

  always_comb begin
    next_state = state;
    res_nxt    = partita;
    case (state)
      S_IDLE:  if (INIZIO) next_state = S_SETUP;
      S_SETUP: next_state = S_GIOCO;
      S_GIOCO: begin
        if (INIZIO) begin
          next_state = S_SETUP;
        end else if (vld_p1) begin
          if (PARTITA_IN != 2'b00) begin
            next_state = S_FINE;
            res_nxt    = PARTITA_IN;
          end else if (n_upd == limit) begin
            next_state = S_FINE;
            res_nxt    = score_result(w1_upd, w2_upd);
          end else if (TIMEOUT != 0 && to_upd == TW'(TIMEOUT)) begin
            next_state = S_FINE;
            res_nxt    = 2'b11;
          end
        end
      end
      S_FINE:  if (INIZIO) next_state = S_SETUP;
      default: next_state = S_IDLE;
    endcase
  end

  // State, strobes and counters; strobes are decoded from next_state so they line up
  // with STATO and at most one can be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      vld_p1   <= 1'b0;
      setup_q  <= 1'b0;
      conto_q  <= 1'b0;
      fine_q   <= 1'b0;
      n_manche <= '0;
      w1       <= '0;
      w2       <= '0;
      limit    <= CNT_W'(BASE_MANCHE);
      to_cnt   <= '0;
      partita  <= 2'b00;
    end else begin
      state   <= next_state;
      vld_p1  <= (state == S_GIOCO) && (next_state == S_GIOCO);
      setup_q <= (next_state == S_SETUP);
      conto_q <= (next_state == S_GIOCO);
      fine_q  <= (next_state == S_FINE) && (state != S_FINE);
      if (next_state == S_SETUP) begin
        limit    <= CNT_W'(BASE_MANCHE) + CNT_W'({PRIMO, SECONDO});
        n_manche <= '0;
        w1       <= '0;
        w2       <= '0;
        to_cnt   <= '0;
        partita  <= 2'b00;
      end else if (state == S_GIOCO) begin
        n_manche <= n_upd;
        w1       <= w1_upd;
        w2       <= w2_upd;
        to_cnt   <= to_upd;
        partita  <= res_nxt;
      end
    end
  end

  assign STATO        = state;
  assign INIZIO_SETUP = setup_q;
  assign INIZIO_CONTO = conto_q;
  assign FINE_CONTO   = fine_q;
  assign N_MANCHE     = n_manche;
  assign PARTITA      = partita;

endmodule

// File: tb/tb_morra_game_ctrl.sv
// Bench for morra_game_ctrl: directed games with expected final results queued at
// stimulus time and compared by a monitor whenever FINE_CONTO fires.
module tb_morra_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       INIZIO;
  logic [1:0] PRIMO, SECONDO, MANCHE_IN, PARTITA_IN;
  logic       INIZIO_SETUP, INIZIO_CONTO, FINE_CONTO;
  logic [1:0] STATO;
  logic [4:0] N_MANCHE;
  logic [1:0] PARTITA;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] partita;
    logic [4:0] n_manche;
  } exp_t;
  exp_t exp_q[$];

  morra_game_ctrl #(.BASE_MANCHE(4), .CNT_W(5), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .INIZIO       (INIZIO),
    .PRIMO        (PRIMO),
    .SECONDO      (SECONDO),
    .MANCHE_IN    (MANCHE_IN),
    .PARTITA_IN   (PARTITA_IN),
    .INIZIO_SETUP (INIZIO_SETUP),
    .INIZIO_CONTO (INIZIO_CONTO),
    .FINE_CONTO   (FINE_CONTO),
    .STATO        (STATO),
    .N_MANCHE     (N_MANCHE),
    .PARTITA      (PARTITA)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic play_round(input logic [1:0] m);
    MANCHE_IN = m;
    step();
    MANCHE_IN = 2'b00;
  endtask

  // Enter SETUP with the given config, then GIOCO, then burn the unsampled first GIOCO cycle.
  task automatic start_game(input logic [3:0] cfg);
    INIZIO = 1'b1;
    {PRIMO, SECONDO} = cfg;
    MANCHE_IN = 2'b00;
    step();
    INIZIO = 1'b0;
    check_val("setup_stato", STATO, 2'b01);
    check_val("setup_strobe", INIZIO_SETUP, 1'b1);
    check_val("setup_conto", INIZIO_CONTO, 1'b0);
    check_val("setup_nmanche", N_MANCHE, 5'd0);
    check_val("setup_partita", PARTITA, 2'b00);
    step();
    check_val("gioco_stato", STATO, 2'b10);
    check_val("gioco_conto", INIZIO_CONTO, 1'b1);
    check_val("gioco_setup_low", INIZIO_SETUP, 1'b0);
    step();
  endtask

  initial begin : monitor
    logic prev_fc;
    exp_t e;
    prev_fc = 1'b0;
    forever begin
      step();
      if (FINE_CONTO) begin
        check_val("fc_single_cycle", prev_fc, 1'b0);
        check_val("sb_expected_avail", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("sb_stato", STATO, 2'b11);
          check_val("sb_conto_low", INIZIO_CONTO, 1'b0);
          check_val("sb_partita", PARTITA, e.partita);
          check_val("sb_nmanche", N_MANCHE, e.n_manche);
        end
      end
      prev_fc = FINE_CONTO;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; INIZIO = 1'b0; PRIMO = 2'b00; SECONDO = 2'b00;
    MANCHE_IN = 2'b00; PARTITA_IN = 2'b00;
    step(); step();
    check_val("rst_stato", STATO, 2'b00);
    check_val("rst_setup", INIZIO_SETUP, 1'b0);
    check_val("rst_conto", INIZIO_CONTO, 1'b0);
    check_val("rst_fine", FINE_CONTO, 1'b0);
    check_val("rst_nmanche", N_MANCHE, 5'd0);
    check_val("rst_partita", PARTITA, 2'b00);
    rst = 1'b0;
    step();
    check_val("idle_hold", STATO, 2'b00);

    // Limit 4: P1 wins 2-1 with one draw
    exp_q.push_back('{2'b01, 5'd4});
    start_game(4'b0000);
    play_round(2'b01); play_round(2'b01); play_round(2'b10);
    check_val("g1_mid_stato", STATO, 2'b10);
    check_val("g1_mid_nmanche", N_MANCHE, 5'd3);
    play_round(2'b11);
    check_val("g1_end_stato", STATO, 2'b11);
    step();
    check_val("g1_fc_drop", FINE_CONTO, 1'b0);
    check_val("g1_hold_stato", STATO, 2'b11);
    check_val("g1_hold_partita", PARTITA, 2'b01);
    check_val("g1_hold_nmanche", N_MANCHE, 5'd4);

    // Limit 4: draw on wins
    exp_q.push_back('{2'b11, 5'd4});
    start_game(4'b0000);
    play_round(2'b01); play_round(2'b10); play_round(2'b11); play_round(2'b11);
    check_val("g2_end_stato", STATO, 2'b11);

    // Limit 4: P2 wins, invalid round not counted
    exp_q.push_back('{2'b10, 5'd4});
    start_game(4'b0000);
    play_round(2'b10); play_round(2'b10); play_round(2'b00);
    play_round(2'b01);
    check_val("g3_mid_stato", STATO, 2'b10);
    play_round(2'b10);
    check_val("g3_end_stato", STATO, 2'b11);

    // Limit 5: datapath declares P2 before the limit
    exp_q.push_back('{2'b10, 5'd2});
    start_game(4'b0001);
    play_round(2'b01); play_round(2'b00); play_round(2'b10);
    PARTITA_IN = 2'b10;
    step();
    PARTITA_IN = 2'b00;
    check_val("g4_end_stato", STATO, 2'b11);

    // Limit 19: timeout restarted by a valid round at sampled cycle 10
    exp_q.push_back('{2'b11, 5'd1});
    start_game(4'b1111);
    repeat (9) play_round(2'b00);
    play_round(2'b01);
    repeat (15) play_round(2'b00);
    check_val("g5_pre_to_stato", STATO, 2'b10);
    check_val("g5_pre_to_nmanche", N_MANCHE, 5'd1);
    play_round(2'b00);
    check_val("g5_to_stato", STATO, 2'b11);
    check_val("g5_to_partita", PARTITA, 2'b11);

    // Restart mid-game: counts and wins clear, limit becomes 6
    exp_q.push_back('{2'b10, 5'd6});
    start_game(4'b0000);
    play_round(2'b01); play_round(2'b01); play_round(2'b01);
    check_val("g6_pre_nmanche", N_MANCHE, 5'd3);
    start_game(4'b0010);
    play_round(2'b10); play_round(2'b10); play_round(2'b11); play_round(2'b11);
    check_val("g6_newlim_stato", STATO, 2'b10);
    check_val("g6_newlim_nmanche", N_MANCHE, 5'd4);
    play_round(2'b11); play_round(2'b11);
    check_val("g6_end_stato", STATO, 2'b11);

    // Reset in GIOCO
    start_game(4'b0000);
    play_round(2'b01);
    check_val("g7_pre_nmanche", N_MANCHE, 5'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("g7_rst_stato", STATO, 2'b00);
    check_val("g7_rst_nmanche", N_MANCHE, 5'd0);
    check_val("g7_rst_conto", INIZIO_CONTO, 1'b0);

    // Reset coinciding with the limit-reaching round: no game end
    start_game(4'b0000);
    play_round(2'b01); play_round(2'b01); play_round(2'b01);
    MANCHE_IN = 2'b01;
    rst = 1'b1;
    step();
    rst = 1'b0;
    MANCHE_IN = 2'b00;
    check_val("g8_rst_stato", STATO, 2'b00);
    check_val("g8_rst_fine", FINE_CONTO, 1'b0);
    check_val("g8_rst_partita", PARTITA, 2'b00);
    step();
    check_val("g8_post_fine", FINE_CONTO, 1'b0);

    // Reset in FINE
    exp_q.push_back('{2'b01, 5'd4});
    start_game(4'b0000);
    repeat (4) play_round(2'b01);
    check_val("g9_end_stato", STATO, 2'b11);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("g9_rst_stato", STATO, 2'b00);
    check_val("g9_rst_partita", PARTITA, 2'b00);
    check_val("g9_rst_nmanche", N_MANCHE, 5'd0);

    step();
    check_val("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
